// File: rtl/sqrt_pipe_hs.sv
// sqrt_pipe_hs -- pipelined restoring integer square root with valid/ready
// handshake, global-stall backpressure and a sideband tag per operand.
//
// Each of the STAGES = WIDTH/(2*BITS_PER_STAGE) register stages resolves
// BITS_PER_STAGE root bits combinationally. The output ports are driven
// straight from the last stage registers.
//
// Optional feature: define SQRT_ROUND_NEAREST_EN to round out_root to nearest
// (saturating at all-ones). out_rem and out_inexact always refer to the floor
// root. With the macro undefined the floor root is emitted unchanged.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous reset, active-low
//   in_valid     operand present
//   in_ready     unit accepts an operand this cycle
//   in_data      unsigned radicand (WIDTH)
//   in_tag       sideband tag (TAG_W)
//   out_valid    result present
//   out_ready    consumer accepts result
//   out_root     floor (or rounded) square root (WIDTH/2)
//   out_rem      in_data - floor_root^2 (WIDTH/2+1)
//   out_inexact  out_rem != 0
//   out_tag      tag of this result
//   busy         any stage holds a valid operand
module sqrt_pipe_hs #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_STAGE = 2,
  parameter int TAG_W          = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-1:0] out_root,
  output logic [WIDTH/2:0]   out_rem,
  output logic               out_inexact,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int HW     = WIDTH / 2;
  localparam int RW     = HW + 2;
  localparam int STAGES = WIDTH / (2 * BITS_PER_STAGE);
  localparam int RAD_N  = (STAGES > 1) ? STAGES - 1 : 1;

  // Partial state carried between stages. Between steps the remainder never
  // exceeds 2*Q, so HW+1 bits suffice in the registers.
  typedef struct packed {
    logic [HW:0]      r;
    logic [HW-1:0]    q;
    logic [WIDTH-1:0] rad;
  } st_t;

  function automatic st_t sqrt_steps(input st_t a);
    st_t           s;
    logic [RW-1:0] rr;
    logic [RW-1:0] t;
    s = a;
    for (int i = 0; i < BITS_PER_STAGE; i++) begin
      // The dropped MSB of s.r is always zero before a further step.
      rr = RW'({s.r, s.rad[WIDTH-1 -: 2]});
      t  = {s.q, 2'b01};
      if (rr >= t) begin
        rr  = rr - t;
        s.q = {s.q[HW-2:0], 1'b1};
      end else begin
        s.q = {s.q[HW-2:0], 1'b0};
      end
      s.r   = rr[HW:0];
      s.rad = {s.rad[WIDTH-3:0], 2'b00};
    end
    return s;
  endfunction

`ifdef SQRT_ROUND_NEAREST_EN
  // rem > root means the true root is >= root + 0.5; ties cannot occur.
  function automatic logic [HW-1:0] round_root(input logic [HW-1:0] q,
                                               input logic [HW:0]   r);
    if ((r > {1'b0, q}) && (q != {HW{1'b1}}))
      return q + 1'b1;
    return q;
  endfunction
`endif

  logic [STAGES-1:0] vld_p;
  logic [HW-1:0]     q_p   [STAGES];
  logic [HW:0]       r_p   [STAGES];
  logic [TAG_W-1:0]  tag_p [STAGES];
  logic [WIDTH-1:0]  rad_p [RAD_N];

  st_t  cur [STAGES];
  st_t  nxt [STAGES];
  logic adv;
  logic accept;

  assign adv      = !out_valid || out_ready;
  assign in_ready = rst && adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    cur[0].r   = '0;
    cur[0].q   = '0;
    cur[0].rad = in_data;
    for (int s = 1; s < STAGES; s++) begin
      cur[s].r   = r_p[s-1];
      cur[s].q   = q_p[s-1];
      cur[s].rad = rad_p[s-1];
    end
    for (int s = 0; s < STAGES; s++)
      nxt[s] = sqrt_steps(cur[s]);
  end

  // Stage boundary: every stage register shifts forward together on adv.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p            <= '0;
      q_p[STAGES-1]    <= '0;
      r_p[STAGES-1]    <= '0;
      tag_p[STAGES-1]  <= '0;
    end else if (adv) begin
      vld_p[0] <= accept;
      tag_p[0] <= in_tag;
      for (int s = 1; s < STAGES; s++) begin
        vld_p[s] <= vld_p[s-1];
        tag_p[s] <= tag_p[s-1];
      end
      for (int s = 0; s < STAGES; s++) begin
        q_p[s] <= nxt[s].q;
        r_p[s] <= nxt[s].r;
      end
      for (int s = 0; s < STAGES - 1; s++)
        rad_p[s] <= nxt[s].rad;
    end
  end

  assign out_valid   = vld_p[STAGES-1];
  assign out_rem     = r_p[STAGES-1];
  assign out_inexact = |r_p[STAGES-1];
  assign out_tag     = tag_p[STAGES-1];
  assign busy        = |vld_p;

`ifdef SQRT_ROUND_NEAREST_EN
  assign out_root = round_root(q_p[STAGES-1], r_p[STAGES-1]);
`else
  assign out_root = q_p[STAGES-1];
`endif

endmodule

// File: tb/tb_sqrt_pipe_hs.sv
// Testbench for sqrt_pipe_hs (WIDTH=16, BITS_PER_STAGE=2, TAG_W=4).
// Expected results come from a brute-force integer square-root model and are
// queued when an operand is accepted; a monitor pops and compares them when
// the DUT hands a result over.
module tb_sqrt_pipe_hs;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [3:0]   in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_root;
  logic [8:0]   out_rem;
  logic         out_inexact;
  logic [3:0]   out_tag;
  logic         busy;

  sqrt_pipe_hs #(.WIDTH(W), .BITS_PER_STAGE(2), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_root(out_root),
    .out_rem(out_rem), .out_inexact(out_inexact), .out_tag(out_tag), .busy(busy)
  );

  typedef struct packed {
    logic [7:0] root;
    logic [8:0] rem;
    logic       inexact;
    logic [3:0] tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic bp_en = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int x, input logic [3:0] t);
    exp_t e;
    int   r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    e.rem     = 9'(x - r * r);
    e.inexact = (x != r * r);
    e.tag     = t;
    e.root    = 8'(r);
`ifdef SQRT_ROUND_NEAREST_EN
    if ((x - r * r) > r && r < 255) e.root = 8'(r + 1);
`endif
    return e;
  endfunction

  // out_ready: always 1 unless the backpressure pattern 1,0,0,1 is enabled.
  initial begin
    logic [3:0] pat;
    int         ph;
    pat = 4'b1001;
    ph  = 0;
    out_ready = 1;
    forever begin
      @(posedge clk); #1;
      if (bp_en) begin
        out_ready = pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        out_ready = 1;
      end
    end
  end

  // Monitor: handshake rule, stall stability and scoreboard comparison.
  logic       prev_stall = 0;
  logic [7:0] h_root;
  logic [8:0] h_rem;
  logic       h_inx;
  logic [3:0] h_tag;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("in_ready_adv", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_root", out_root, h_root);
        check("hold_rem", out_rem, h_rem);
        check("hold_inexact", out_inexact, h_inx);
        check("hold_tag", out_tag, h_tag);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", out_valid, 0);
        end else begin
          e = sb.pop_front();
          check("root", out_root, e.root);
          check("rem", out_rem, e.rem);
          check("inexact", out_inexact, e.inexact);
          check("tag", out_tag, e.tag);
        end
      end
    end
    prev_stall <= rst && out_valid && !out_ready;
    h_root     <= out_root;
    h_rem      <= out_rem;
    h_inx      <= out_inexact;
    h_tag      <= out_tag;
  end

  // Hold the operand until the DUT takes it; the expectation is queued once.
  task automatic send(input int d, input logic [3:0] t);
    bit done;
    done = 0;
    in_data  = W'(d);
    in_tag   = t;
    in_valid = 1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(d, t));
        acc_cyc = cyc;
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("accept_timeout", in_ready, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 2000 && sb.size() != 0; n++) @(posedge clk);
    check("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
    check("drain_busy", busy, 0);
  endtask

  initial begin
    bit seen;
    rst = 0; in_valid = 0; in_data = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_root", out_root, 0);
    check("rst_rem", out_rem, 0);
    check("rst_inexact", out_inexact, 0);
    check("rst_tag", out_tag, 0);
    @(posedge clk); #1;
    rst = 1;

    // Single operand: latency and result.
    send(144, 4'd3);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("latency", cyc - acc_cyc, 4);
    drain();

    // Back-to-back including both boundaries.
    send(0, 4'd0);
    send(1, 4'd1);
    send(157, 4'd2);
    send(65535, 4'd4);
    drain();

    // Backpressure with 10 operands.
    bp_en = 1;
    for (int i = 0; i < 10; i++) send(i * 6311 + 7, 4'(i));
    drain();
    bp_en = 0;

    // Reset while three operands are in flight.
    send(400, 4'd5);
    send(401, 4'd6);
    send(402, 4'd7);
    rst = 0;
    sb.delete();
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_root", out_root, 0);
    check("mid_rst_rem", out_rem, 0);
    check("mid_rst_inexact", out_inexact, 0);
    check("mid_rst_tag", out_tag, 0);
    repeat (10) @(posedge clk);
    #1;

    // Sweep of the radicand range plus the top-end boundaries.
    for (int x = 0; x < 65536; x += 5) send(x, x[3:0]);
    send(65024, 4'd8);
    send(65025, 4'd9);
    send(65534, 4'd10);
    send(65535, 4'd11);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
